// File: rtl/inport_ctrl.sv
// Router input port: buffers flits, requests the head flit's output port, then streams the packet.
// Latency: head push to req is 1 cycle; pops follow the grant by 1 cycle. Backpressure: in_ready = !full, pops wait on out_ready.
module inport_ctrl #(
  parameter int PORTID = 0,
  parameter int DATAW  = 32,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DATAW-1:0] in_data,
  input  logic             in_head,
  input  logic             in_tail,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             req,
  output logic [2:0]       port,
  input  logic [4:0]       grt_in,
  output logic [DATAW-1:0] out_data,
  output logic             out_head,
  output logic             out_tail,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             drop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("inport_ctrl: DEPTH must be a power of two >= 2");
  end
  if (PORTID < 0 || PORTID > 4) begin : g_bad_portid
    $error("inport_ctrl %0d: PORTID must be 0..4", PORTID);
  end

  typedef struct packed {
    logic             head;
    logic             tail;
    logic [DATAW-1:0] data;
  } flit_t;

  typedef enum logic [1:0] {IDLE, REQ, SEND, DROP} state_t;

  flit_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;
  flit_t         top;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic [2:0]    dest;
  logic [7:0]    grt_ext;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign top      = mem[rd_ptr];
  assign dest     = top.data[2:0];
  assign grt_ext  = {3'b000, grt_in};

  assign out_data  = top.data;
  assign out_head  = top.head;
  assign out_tail  = top.tail;
  assign out_valid = (state == SEND) && !empty;

  // IDLE silently discards stray body/tail flits; heads stay put until REQ/DROP consumes them.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      unique case (state)
        IDLE:    pop = !top.head;
        SEND:    pop = out_ready;
        DROP:    pop = 1'b1;
        default: pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{head: in_head, tail: in_tail, data: in_data};
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // req drops with the tail pop, forcing one IDLE cycle so the output controller can rotate.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= IDLE;
      req      <= 1'b0;
      port     <= 3'd0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!empty && top.head) begin
            if (dest <= 3'd4) begin
              state <= REQ;
              req   <= 1'b1;
              port  <= dest;
            end else begin
              state    <= DROP;
              drop_err <= 1'b1;
            end
          end
        end
        REQ: begin
          if (grt_ext[port]) state <= SEND;
        end
        SEND: begin
          if (pop && top.tail) begin
            state <= IDLE;
            req   <= 1'b0;
          end
        end
        DROP: begin
          if (pop && top.tail) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inport_ctrl.sv
// Bench for inport_ctrl: packet-level reference model feeds a scoreboard; a negedge monitor checks every forwarded flit.
module tb_inport_ctrl;
  localparam int DATAW = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_ = 1'b0;
  logic [DATAW-1:0] in_data = '0;
  logic             in_head = 1'b0;
  logic             in_tail = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             req;
  logic [2:0]       port;
  logic [4:0]       grt_in;
  logic [DATAW-1:0] out_data;
  logic             out_head;
  logic             out_tail;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             drop_err;

  typedef struct packed {
    logic [2:0]       dest;
    logic             head;
    logic             tail;
    logic [DATAW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int vectors = 0, miscompares = 0;
  int cyc = 0, tot_push = 0, head_acc_cyc = 0;
  int drops_exp = 0, drops_seen = 0;
  int req_rises = 0, req_rise_cyc = 0, hi_cnt = 0, last_hi_len = 0, low_run = 0, last_low_run = 0;
  int pop_cnt = 0, first_pop_cyc = 0, last_pop_cyc = 0;
  logic req_prev = 1'b0, drop_prev = 1'b0, prev_tail_pop = 1'b0;
  logic gnt_en = 1'b0, rand_on = 1'b0;
  logic [4:0] noise = '0;

  inport_ctrl #(.PORTID(2), .DATAW(DATAW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_(rst_),
    .in_data(in_data), .in_head(in_head), .in_tail(in_tail), .in_valid(in_valid), .in_ready(in_ready),
    .req(req), .port(port), .grt_in(grt_in),
    .out_data(out_data), .out_head(out_head), .out_tail(out_tail), .out_valid(out_valid), .out_ready(out_ready),
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Output-controller stand-in: grant on the requested port, random noise on the others.
  assign grt_in = (noise & ~(5'b00001 << port)) | ((req && gnt_en) ? (5'b00001 << port) : 5'b00000);

  always @(posedge clk) begin
    #1;
    if (rand_on) begin
      gnt_en    = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      noise     = 5'($urandom);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_) begin
      prev_tail_pop = 1'b0;
      req_prev = 1'b0;
      drop_prev = 1'b0;
      low_run = 0;
      hi_cnt = 0;
    end else begin
      if (prev_tail_pop) check("after_tail_req_vld", 64'({req, out_valid}), 64'd0);
      prev_tail_pop = 1'b0;
      if (req && !req_prev) begin
        req_rises++;
        req_rise_cyc = cyc;
        last_low_run = low_run;
        hi_cnt = 0;
      end
      if (!req && req_prev) last_hi_len = hi_cnt;
      if (req) begin
        hi_cnt++;
        low_run = 0;
      end else begin
        low_run++;
      end
      if (drop_err) begin
        drops_seen++;
        check("drop_pulse", 64'({drop_prev, req}), 64'd0);
      end
      drop_prev = drop_err;
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (pop_cnt == 1) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_flit", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("flit", 64'({out_head, out_tail, out_data}), 64'({e.head, e.tail, e.data}));
          check("req_port", 64'({req, port}), 64'({1'b1, e.dest}));
          prev_tail_pop = out_tail;
        end
      end
      req_prev = req;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called at #1 after a rising edge; returns #1 after the accepting edge.
  task automatic push_flit(input logic h, input logic t, input logic [DATAW-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_head = h;
    in_tail = t;
    in_data = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", 64'(in_ready), 64'd1);
    sync();
    if (h) head_acc_cyc = cyc;
    in_valid = 1'b0;
    tot_push++;
  endtask

  task automatic send_pkt(input logic [2:0] dest, input int len, input int gap_max);
    logic [DATAW-1:0] d;
    logic h, t;
    for (int i = 0; i < len; i++) begin
      d = $urandom;
      if (i == 0) d[2:0] = dest;
      h = (i == 0);
      t = (i == len - 1);
      if (dest <= 3'd4) exp_q.push_back({dest, h, t, d});
      push_flit(h, t, d);
      repeat ($urandom_range(0, gap_max)) sync();
    end
    if (dest > 3'd4) drops_exp++;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || req || out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    sync();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, base, pc0;
    logic [2:0] dst;

    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({in_ready, req, out_valid, drop_err}), 64'b1000);
    rst_ = 1'b1;
    sync();
    sync();
    check("idle_outputs", 64'({in_ready, req, port, out_valid, drop_err}), 64'b1_0_000_0_0);

    // 3-flit packet to port 2, grant two cycles after req
    gnt_en = 1'b0;
    out_ready = 1'b1;
    r0 = req_rises;
    pop_cnt = 0;
    send_pkt(3'd2, 3, 0);
    check("t2_req_rises", 64'(req_rises), 64'(r0 + 1));
    check("t2_req_latency", 64'(req_rise_cyc), 64'(head_acc_cyc + 1));
    check("t2_req_port", 64'({req, port}), 64'({1'b1, 3'd2}));
    while (cyc < req_rise_cyc + 2) sync();
    check("t2_no_pop_before_grant", 64'(pop_cnt), 64'd0);
    gnt_en = 1'b1;
    wait_idle("t2_drain");
    check("t2_pop_count", 64'(pop_cnt), 64'd3);
    check("t2_first_pop", 64'(first_pop_cyc), 64'(req_rise_cyc + 3));
    check("t2_consecutive", 64'(last_pop_cyc), 64'(first_pop_cyc + 2));

    // single-flit packet to port 4, immediate grant
    r0 = req_rises;
    send_pkt(3'd4, 1, 0);
    wait_idle("t3_drain");
    check("t3_req_rises", 64'(req_rises), 64'(r0 + 1));
    check("t3_req_high_len", 64'(last_hi_len), 64'd2);

    // invalid destination: dropped, then a normal packet
    r0 = req_rises;
    send_pkt(3'd6, 3, 0);
    wait_idle("t4_drop_drain");
    check("t4_no_req", 64'(req_rises), 64'(r0));
    check("t4_drop_count", 64'(drops_seen), 64'(drops_exp));
    send_pkt(3'd0, 2, 1);
    wait_idle("t4_next_drain");
    check("t4_next_req", 64'(req_rises), 64'(r0 + 1));

    // FIFO fill while stalled in SEND, then drain with concurrent pushes
    out_ready = 1'b0;
    base = tot_push;
    pc0 = pop_cnt;
    fork
      send_pkt(3'd3, 8, 0);
      begin
        wait (tot_push == base + DEPTH);
        check("t5_full_in_ready", 64'(in_ready), 64'd0);
        repeat (5) @(negedge clk);
        check("t5_stall_state", 64'({in_ready, out_valid, req}), 64'b011);
        check("t5_stall_no_pop", 64'(pop_cnt), 64'(pc0));
        sync();
        out_ready = 1'b1;
      end
    join
    wait_idle("t5_drain");

    // back-to-back packets to port 1 with grant held
    send_pkt(3'd1, 2, 0);
    send_pkt(3'd1, 3, 0);
    wait_idle("t6_drain");
    check("t6_gap", 64'(last_low_run), 64'd1);

    // randomized traffic
    rand_on = 1'b1;
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 3) == 0) dst = 3'($urandom_range(5, 7));
      else dst = 3'($urandom_range(0, 4));
      send_pkt(dst, $urandom_range(1, 5), 2);
      if ($urandom_range(0, 7) == 0) push_flit(1'b0, 1'($urandom_range(0, 1)), $urandom);
    end
    rand_on = 1'b0;
    sync();
    gnt_en = 1'b1;
    out_ready = 1'b1;
    noise = '0;
    wait_idle("rand_drain");
    check("rand_drops", 64'(drops_seen), 64'(drops_exp));

    // asynchronous reset in the middle of SEND
    out_ready = 1'b0;
    send_pkt(3'd0, 4, 0);
    repeat (3) @(negedge clk);
    check("mid_send_state", 64'({out_valid, req, in_ready}), 64'b110);
    #2;
    rst_ = 1'b0;
    #1;
    check("async_reset", 64'({in_ready, req, port, out_valid, drop_err}), 64'b1_0_000_0_0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    sync();
    sync();
    check("post_reset_idle", 64'({in_ready, req, out_valid}), 64'b100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
